block_field: RTL and testbench

- Owns the Breakout brick wall: an NROWS x NCOLS alive-bit grid, its vertical offset, and its periodic descent.
- On each frame tick, tests the ball position against the grid. On a hit it clears the brick and pulses hit_block and bounce.
- Raises endgame_block when the wall reaches the floor limit.
- Sits directly upstream of the scoreboard, which consumes hit_block, endgame_block and start. It also serves per-pixel brick queries to the VGA renderer.

---
 rtl/block_field.sv | 173 +++++++++++++++++
 tb/tb_block_field.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_field.sv
// Breakout brick wall: alive-bit grid, descending vertical offset, ball collision
// against the wall on frame ticks, endgame detection and per-pixel brick lookup.
module block_field #(
    parameter int NCOLS       = 10,
    parameter int NROWS       = 4,
    parameter int BLK_W_LOG2  = 6,
    parameter int BLK_H_LOG2  = 4,
    parameter int TOP_Y       = 32,
    parameter int LIMIT_Y     = 400,
    parameter int DESC_FRAMES = 600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       restart,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic       hit_block,
    output logic       bounce,
    output logic       endgame_block,
    output logic       all_clear,
    output logic       block_pixel,
    output logic [9:0] wall_y
);

    localparam int ROW_W = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int CX_W  = 10 - BLK_W_LOG2;
    localparam int RY_W  = 10 - BLK_H_LOG2;
    localparam int CNT_W = (DESC_FRAMES > 1) ? $clog2(DESC_FRAMES) : 1;
    localparam logic [9:0] BLK_H = 10'(1 << BLK_H_LOG2);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;

    state_t           state_reg, state_next;
    logic [NCOLS-1:0] grid_reg [NROWS];
    logic [NROWS-1:0] row_any;
    logic [9:0]       y_off_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CX_W-1:0]  hit_col_reg;
    logic [ROW_W-1:0] hit_row_reg;
    logic             hit_valid_reg;
    logic             hit_block_reg;
    logic             all_clear_reg;
    logic             block_pixel_reg;

    logic             clear_all;
    logic             run_tick;
    logic             hit_commit;
    logic [3:0]       lowest;
    logic [10:0]      wall_bottom;
    logic             endgame_cond;

    // Ball to brick mapping
    logic [CX_W-1:0]  ball_col;
    logic [9:0]       ball_rel;
    logic [RY_W-1:0]  ball_rowf;
    logic             ball_in;

    // Renderer pixel to brick mapping (same mapping, plus 1-px gap)
    logic [CX_W-1:0]  pix_col;
    logic [9:0]       pix_rel;
    logic [RY_W-1:0]  pix_rowf;
    logic [ROW_W-1:0] pix_row;
    logic             pix_in;
    logic             pix_on;

    assign clear_all = reset || restart;
    assign run_tick  = (state_reg == RUN) && frame_tick;

    assign ball_col  = ball_x[9:BLK_W_LOG2];
    assign ball_rel  = ball_y - y_off_reg;
    assign ball_rowf = ball_rel[9:BLK_H_LOG2];
    assign ball_in   = (ball_y >= y_off_reg) && (32'(ball_col) < NCOLS) && (32'(ball_rowf) < NROWS);

    assign pix_col   = px[9:BLK_W_LOG2];
    assign pix_rel   = py - y_off_reg;
    assign pix_rowf  = pix_rel[9:BLK_H_LOG2];
    assign pix_row   = ROW_W'(pix_rowf);
    assign pix_in    = (py >= y_off_reg) && (32'(pix_col) < NCOLS) && (32'(pix_rowf) < NROWS)
                       && (px[BLK_W_LOG2-1:0] != '1) && (pix_rel[BLK_H_LOG2-1:0] != '1);
    assign pix_on    = pix_in && grid_reg[pix_row][pix_col];

    // A hit only lands if the game is still running when the grid is updated
    assign hit_commit = hit_valid_reg && (state_reg == RUN) && grid_reg[hit_row_reg][hit_col_reg];

    generate
        for (genvar gi = 0; gi < NROWS; gi++) begin : g_row
            always_ff @(posedge clock) begin
                if (clear_all) begin
                    grid_reg[gi] <= '1;
                end else if (hit_commit && (hit_row_reg == ROW_W'(gi))) begin
                    grid_reg[gi][hit_col_reg] <= 1'b0;
                end
            end
            assign row_any[gi] = |grid_reg[gi];
        end
    endgenerate

    always_comb begin
        lowest = '0;
        for (int r = 0; r < NROWS; r++) begin
            if (row_any[r]) lowest = 4'(r);
        end
    end

    assign wall_bottom  = {1'b0, y_off_reg} + ((11'(lowest) + 11'd1) << BLK_H_LOG2);
    assign endgame_cond = (row_any != '0) && (wall_bottom >= 11'(LIMIT_Y));

    always_ff @(posedge clock) begin
        if (clear_all) state_reg <= IDLE;
        else           state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                if (endgame_cond) state_next = OVER;
                else if (!start)  state_next = PAUSE;
            end
            PAUSE:   if (start) state_next = RUN;
            OVER:    state_next = OVER;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear_all) begin
            y_off_reg <= 10'(TOP_Y);
            cnt_reg   <= '0;
        end else if (run_tick) begin
            if (32'(cnt_reg) == DESC_FRAMES - 1) begin
                cnt_reg <= '0;
                if (!all_clear_reg) y_off_reg <= y_off_reg + BLK_H;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear_all) begin
            hit_valid_reg <= 1'b0;
            hit_col_reg   <= '0;
            hit_row_reg   <= '0;
            hit_block_reg <= 1'b0;
            all_clear_reg <= 1'b0;
        end else begin
            hit_valid_reg <= run_tick && ball_in;
            hit_col_reg   <= ball_col;
            hit_row_reg   <= ROW_W'(ball_rowf);
            hit_block_reg <= hit_commit;
            all_clear_reg <= (row_any == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) block_pixel_reg <= 1'b0;
        else       block_pixel_reg <= pix_on;
    end

    assign hit_block     = hit_block_reg;
    assign bounce        = hit_block_reg;
    assign endgame_block = (state_reg == OVER);
    assign all_clear     = all_clear_reg;
    assign block_pixel   = block_pixel_reg;
    assign wall_y        = y_off_reg;

endmodule

// File: tb/tb_block_field.sv
// Randomised scoreboard bench for block_field: stimulus pushes expected tick and
// pixel responses, a negedge monitor pops and compares them against the DUT.
module tb_block_field;

    localparam int DESC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] ball_x = '0, ball_y = '0, px = '0, py = '0;
    logic       hit_block, bounce, endgame_block, all_clear, block_pixel;
    logic [9:0] wall_y;

    block_field #(.DESC_FRAMES(DESC)) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .restart(restart), .ball_x(ball_x), .ball_y(ball_y), .px(px), .py(py),
        .hit_block(hit_block), .bounce(bounce), .endgame_block(endgame_block),
        .all_clear(all_clear), .block_pixel(block_pixel), .wall_y(wall_y)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural wall model
    bit grid_m [4][10];
    int yoff_m, cnt_m;
    bit over_m;

    typedef struct {
        bit hit;
        int wall;
        bit over;
    } exp_t;
    exp_t tick_q[$];
    bit   pix_q[$];
    bit   pix_strobe = 1'b0;

    function automatic void model_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 10; c++) grid_m[r][c] = 1'b1;
        yoff_m = 32;
        cnt_m  = 0;
        over_m = 1'b0;
    endfunction

    function automatic bit empty_m();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 10; c++) if (grid_m[r][c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int lowest_m();
        int low = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 10; c++) if (grid_m[r][c]) low = r;
        return low;
    endfunction

    function automatic bit pix_model(int x, int y);
        int col, rel, row;
        if (y < yoff_m) return 1'b0;
        col = x / 64;
        if (col >= 10) return 1'b0;
        rel = y - yoff_m;
        row = rel / 16;
        if (row >= 4) return 1'b0;
        if ((x % 64) == 63 || (rel % 16) == 15) return 1'b0;
        return grid_m[row][col];
    endfunction

    task automatic do_tick(int bx, int by);
        exp_t e;
        int   col, row;
        bit   was_empty;
        e.hit = 1'b0;
        row = 0;
        col = bx / 64;
        if (start && !over_m) begin
            was_empty = empty_m();
            if (by >= yoff_m && col < 10 && (by - yoff_m) / 16 < 4) begin
                row = (by - yoff_m) / 16;
                e.hit = grid_m[row][col];
            end
            if (cnt_m == DESC - 1) begin
                cnt_m = 0;
                if (!was_empty) yoff_m += 16;
            end else begin
                cnt_m++;
            end
            if (!empty_m() && yoff_m + (lowest_m() + 1) * 16 >= 400) over_m = 1'b1;
            if (e.hit) grid_m[row][col] = 1'b0;
        end
        e.wall = yoff_m;
        e.over = over_m;
        tick_q.push_back(e);
        @(posedge clock); #1;
        ball_x = 10'(bx);
        ball_y = 10'(by);
        frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic set_start(bit v);
        @(posedge clock); #1;
        start = v;
        repeat (3) @(posedge clock);
    endtask

    task automatic do_restart();
        @(posedge clock); #1;
        restart = 1'b1;
        @(posedge clock); #1;
        restart = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
    endtask

    task automatic pix(int x, int y);
        @(posedge clock); #1;
        px = 10'(x);
        py = 10'(y);
        pix_strobe = 1'b1;
        pix_q.push_back(pix_model(x, y));
    endtask

    task automatic pix_done();
        @(posedge clock); #1;
        pix_strobe = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic pix_random(int n);
        for (int i = 0; i < n; i++) pix($urandom_range(0, 1023), $urandom_range(0, 200));
        pix_done();
    endtask

    // Monitor: tick responses appear two cycles after the tick, pixels one cycle after
    initial begin
        bit   t1, t2, p1;
        exp_t e;
        bit   pe;
        t1 = 1'b0; t2 = 1'b0; p1 = 1'b0;
        forever begin
            @(negedge clock);
            if (t2) begin
                if (tick_q.size() == 0) begin
                    check("tick_queue_underflow", 1, 0);
                end else begin
                    e = tick_q.pop_front();
                    check("hit_block", int'(hit_block), int'(e.hit));
                    check("bounce", int'(bounce), int'(e.hit));
                    check("wall_y", int'(wall_y), e.wall);
                    check("endgame_block", int'(endgame_block), int'(e.over));
                    $display("tick: hit=%0b wall_y=%0d endgame=%0b (expected %0b %0d %0b)",
                             hit_block, wall_y, endgame_block, e.hit, e.wall, e.over);
                end
            end else if (hit_block || bounce) begin
                check("spurious_hit", 1, 0);
            end
            t2 = t1;
            t1 = frame_tick;
            if (p1) begin
                if (pix_q.size() == 0) begin
                    check("pixel_queue_underflow", 1, 0);
                end else begin
                    pe = pix_q.pop_front();
                    check("block_pixel", int'(block_pixel), int'(pe));
                end
            end
            p1 = pix_strobe;
        end
    end

    initial begin
        int bx, by, n;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("reset_wall_y", int'(wall_y), 32);
        check("reset_hit_block", int'(hit_block), 0);
        check("reset_bounce", int'(bounce), 0);
        check("reset_endgame", int'(endgame_block), 0);
        check("reset_all_clear", int'(all_clear), 0);
        check("reset_block_pixel", int'(block_pixel), 0);

        // Brick edges and gap around brick (0,0) and its neighbours
        begin
            int xs[11] = '{0, 1, 31, 62, 63, 64, 65, 127, 639, 640, 700};
            int ys[9]  = '{31, 32, 40, 46, 47, 48, 95, 96, 100};
            foreach (xs[i]) foreach (ys[j]) pix(xs[i], ys[j]);
            pix_done();
        end

        set_start(1'b1);
        do_tick(100, 40);
        do_tick(100, 40);
        do_tick(700, 40);
        do_tick(100, yoff_m - 12);
        do_tick(100, yoff_m + 68);
        pix_random(40);

        // Pause: ticks must be ignored, then counting resumes
        set_start(1'b0);
        for (int i = 0; i < 10; i++) do_tick($urandom_range(0, 700), yoff_m + 5);
        set_start(1'b1);
        for (int i = 0; i < 3; i++) do_tick(700, 40);

        // Random play until well past the endgame
        for (int i = 0; i < 70; i++) begin
            bx = $urandom_range(0, 700);
            by = yoff_m + int'($urandom_range(0, 90)) - 10;
            if (by < 0) by = 0;
            do_tick(bx, by);
        end
        @(negedge clock);
        check("random_endgame_level", int'(endgame_block), int'(over_m));

        do_restart();
        @(negedge clock);
        check("restart_wall_y", int'(wall_y), 32);
        check("restart_endgame", int'(endgame_block), 0);
        check("restart_all_clear", int'(all_clear), 0);
        pix_random(30);

        // Pure descent to the floor
        for (int i = 0; i < 38; i++) do_tick(700, 40);
        @(negedge clock);
        check("descent_final_wall_y", int'(wall_y), 336);
        check("descent_endgame", int'(endgame_block), 1);
        for (int i = 0; i < 3; i++) do_tick(700, 40);

        // Bottom row removed first: floor reached one step later
        do_restart();
        for (int c = 0; c < 10; c++) do_tick(c * 64 + 5, yoff_m + 51);
        n = 0;
        while (!over_m && n < 60) begin
            do_tick(700, 40);
            n++;
        end
        @(negedge clock);
        check("row3_endgame_wall_y", int'(wall_y), 352);
        check("row3_endgame", int'(endgame_block), 1);

        // Clear the whole wall bottom-up; descent must then stop
        do_restart();
        for (int r = 3; r >= 0; r--)
            for (int c = 0; c < 10; c++) do_tick(c * 64 + 5, yoff_m + r * 16 + 3);
        @(negedge clock);
        check("all_clear_level", int'(all_clear), 1);
        for (int i = 0; i < 4; i++) do_tick(700, 40);
        @(negedge clock);
        check("all_clear_no_endgame", int'(endgame_block), 0);
        pix_random(20);

        repeat (4) @(posedge clock);
        check("tick_queue_drained", tick_q.size(), 0);
        check("pixel_queue_drained", pix_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
